// File: rtl/io_output_bank.sv
// Bank of memory-mapped output registers with SET/CLEAR aliases, per-bit hardware
// blink driven by a shared prescaler, and registered 1-cycle readback.
module io_output_bank #(
  parameter logic [31:0]          BASE_ADDRESS = 32'h0,
  parameter int                   NUM_REGS     = 6,
  parameter int                   REG_WIDTH    = 18,
  parameter logic [NUM_REGS-1:0]  RESET_MASK   = '0,
  parameter int                   BLINK_DIVIDE = 25000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          io_write_en,
  input  logic                          io_read_en,
  input  logic [31:0]                   io_address,
  input  logic [31:0]                   io_write_data,
  output logic [31:0]                   io_read_data,
  output logic [NUM_REGS*REG_WIDTH-1:0] out_o,
  output logic                          blink_phase
);

  localparam int                CNT_W       = $clog2(BLINK_DIVIDE);
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(BLINK_DIVIDE - 1);
  localparam logic [31:0]       CTRL_OFFSET = 32'(16 * NUM_REGS);

  typedef logic [REG_WIDTH-1:0] word_t;
  typedef enum logic [1:0] {REG_VALUE, REG_SET, REG_CLEAR, REG_BLINK} reg_sel_e;

  function automatic word_t reset_value(input int ch);
    return RESET_MASK[ch] ? '1 : '0;
  endfunction

  word_t            value_q    [NUM_REGS];
  word_t            value_d    [NUM_REGS];
  word_t            blink_en_q [NUM_REGS];
  word_t            blink_en_d [NUM_REGS];
  word_t            out_q      [NUM_REGS];
  word_t            out_d      [NUM_REGS];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [31:0]      rd_q, rd_d, rd_mux;

  logic [31:0] offset;
  logic [27:0] ch_idx;
  reg_sel_e    reg_sel;
  logic        hit_ch, hit_ctrl, restart;
  word_t       wdata;
  logic        unused_wdata;

  // Decode relative to the base so each channel is a 16-byte window.
  assign offset       = io_address - BASE_ADDRESS;
  assign ch_idx       = offset[31:4];
  assign reg_sel      = reg_sel_e'(offset[3:2]);
  assign hit_ch       = (offset[1:0] == 2'b00) && (ch_idx < 28'(NUM_REGS));
  assign hit_ctrl     = (offset == CTRL_OFFSET);
  assign restart      = io_write_en && hit_ctrl && io_write_data[0];
  assign wdata        = io_write_data[REG_WIDTH-1:0];
  assign unused_wdata = ^io_write_data;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    value_d    = value_q;
    blink_en_d = blink_en_q;
    rd_mux     = '0;

    for (int i = 0; i < NUM_REGS; i++) begin
      if (hit_ch && (ch_idx == 28'(i))) begin
        case (reg_sel)
          REG_VALUE: begin
            rd_mux = 32'(value_q[i]);
            if (io_write_en) value_d[i] = wdata;
          end
          REG_SET: begin
            rd_mux = 32'(out_q[i]);
            if (io_write_en) value_d[i] = value_q[i] | wdata;
          end
          REG_CLEAR: begin
            if (io_write_en) value_d[i] = value_q[i] & ~wdata;
          end
          REG_BLINK: begin
            rd_mux = 32'(blink_en_q[i]);
            if (io_write_en) blink_en_d[i] = wdata;
          end
          default: ;
        endcase
      end
    end
    if (hit_ctrl) rd_mux = {31'b0, phase_q};

    // A restart takes priority over the terminal-count toggle.
    if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
      phase_d = phase_q;
    end

    // Display is registered from next state so out_o always agrees with blink_phase.
    for (int i = 0; i < NUM_REGS; i++) begin
      out_d[i] = value_d[i] ^ (blink_en_d[i] & {REG_WIDTH{phase_d}});
    end

    rd_d = io_read_en ? rd_mux : rd_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        value_q[i]    <= reset_value(i);
        blink_en_q[i] <= '0;
        out_q[i]      <= reset_value(i);
      end
      cnt_q   <= '0;
      phase_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        value_q[i]    <= value_d[i];
        blink_en_q[i] <= blink_en_d[i];
        out_q[i]      <= out_d[i];
      end
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      rd_q    <= rd_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign out_o[g*REG_WIDTH +: REG_WIDTH] = out_q[g];
  end

  assign blink_phase  = phase_q;
  assign io_read_data = rd_q;

endmodule

// File: tb/tb_io_output_bank.sv
// Self-checking bench for io_output_bank: directed scenarios plus a random run,
// all compared against a behavioural register-map model.
module tb_io_output_bank;

  localparam int NR = 6;
  localparam int RW = 18;
  localparam int BD = 4;
  localparam logic [31:0] CTRL = 32'h60;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              io_write_en = 1'b0;
  logic              io_read_en = 1'b0;
  logic [31:0]       io_address = '0;
  logic [31:0]       io_write_data = '0;
  logic [31:0]       io_read_data;
  logic [NR*RW-1:0]  out_o;
  logic              blink_phase;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  io_output_bank #(
    .BASE_ADDRESS (32'h0),
    .NUM_REGS     (NR),
    .REG_WIDTH    (RW),
    .RESET_MASK   (6'b111100),
    .BLINK_DIVIDE (BD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .io_write_en   (io_write_en),
    .io_read_en    (io_read_en),
    .io_address    (io_address),
    .io_write_data (io_write_data),
    .io_read_data  (io_read_data),
    .out_o         (out_o),
    .blink_phase   (blink_phase)
  );

  // ---------------- reference model ----------------
  logic [RW-1:0] m_val [NR];
  logic [RW-1:0] m_ben [NR];
  int            m_cyc;   // clock edges since reset or last restart
  logic [31:0]   m_rd;

  function automatic logic m_phase();
    return ((m_cyc / BD) % 2) == 1;
  endfunction

  function automatic logic [RW-1:0] m_disp(input int c);
    return m_phase() ? (m_val[c] ^ m_ben[c]) : m_val[c];
  endfunction

  function automatic logic [NR*RW-1:0] m_out();
    logic [NR*RW-1:0] r;
    for (int c = 0; c < NR; c++) r[c*RW +: RW] = m_disp(c);
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int c;
    if (a == CTRL) return {31'b0, m_phase()};
    if (a[1:0] != 2'b00 || a >= CTRL) return 32'h0;
    c = int'(a / 16);
    case ((a % 16) / 4)
      0:       return 32'(m_val[c]);
      1:       return 32'(m_disp(c));
      3:       return 32'(m_ben[c]);
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NR; c++) begin
      m_val[c] = (c >= 2) ? '1 : '0;
      m_ben[c] = '0;
    end
    m_cyc = 0;
    m_rd  = 32'h0;
  endtask

  task automatic m_edge(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic        rs;
    int          c;
    r  = m_read(a);
    rs = 1'b0;
    if (we) begin
      if (a == CTRL) rs = d[0];
      else if (a[1:0] == 2'b00 && a < CTRL) begin
        c = int'(a / 16);
        case ((a % 16) / 4)
          0: m_val[c] = d[RW-1:0];
          1: m_val[c] = m_val[c] | d[RW-1:0];
          2: m_val[c] = m_val[c] & ~d[RW-1:0];
          default: m_ben[c] = d[RW-1:0];
        endcase
      end
    end
    if (re) m_rd = r;
    m_cyc = rs ? 0 : m_cyc + 1;
  endtask

  // One bus cycle; returns 1 ns after the active edge.
  task automatic step(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    io_write_en   = we;
    io_read_en    = re;
    io_address    = a;
    io_write_data = d;
    @(posedge clk);
    m_edge(we, re, a, d);
    #1;
    io_write_en = 1'b0;
    io_read_en  = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    m_reset();
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (out_o !== m_out()) begin
      errors++; $display("FAIL reset_out: got %h expected %h", out_o, m_out());
    end
    checks++;
    if (blink_phase !== 1'b0 || io_read_data !== 32'h0) begin
      errors++; $display("FAIL reset_phase_rd: got phase=%b rd=%h expected 0/0", blink_phase, io_read_data);
    end
    reset = 1'b0;
    step(1'b0, 1'b1, 32'h20, 32'h0);
    checks++;
    if (io_read_data !== 32'h0003FFFF) begin
      errors++; $display("FAIL reset_read20: got %h expected 0003ffff", io_read_data);
    end
    step(1'b0, 1'b1, CTRL, 32'h0);
    checks++;
    if (io_read_data !== 32'h0) begin
      errors++; $display("FAIL reset_read60: got %h expected 0", io_read_data);
    end
  endtask

  task automatic test_value_set_clear();
    step(1'b1, 1'b0, 32'h00, 32'hFFFFFFFF);
    checks++;
    if (out_o[0 +: RW] !== 18'h3FFFF || out_o !== m_out()) begin
      errors++; $display("FAIL value_write_ch0: got %h expected %h", out_o, m_out());
    end
    step(1'b0, 1'b1, 32'h00, 32'h0);
    checks++;
    if (io_read_data !== 32'h0003FFFF) begin
      errors++; $display("FAIL value_readback: got %h expected 0003ffff", io_read_data);
    end
    step(1'b1, 1'b0, 32'h14, 32'h5);
    step(1'b1, 1'b0, 32'h18, 32'h1);
    checks++;
    if (out_o[RW +: RW] !== 18'h00004 || out_o !== m_out()) begin
      errors++; $display("FAIL set_clear_ch1: got %h expected 00004", out_o[RW +: RW]);
    end
    step(1'b1, 1'b0, 32'h14, 32'h0);
    step(1'b1, 1'b0, 32'h18, 32'h0);
    checks++;
    if (out_o[RW +: RW] !== 18'h00004) begin
      errors++; $display("FAIL set_clear_zero: got %h expected 00004", out_o[RW +: RW]);
    end
    step(1'b0, 1'b1, 32'h18, 32'h0);
    checks++;
    if (io_read_data !== 32'h0) begin
      errors++; $display("FAIL clear_read: got %h expected 0", io_read_data);
    end
  endtask

  task automatic test_blink();
    int changes;
    logic [RW-1:0] prev;
    step(1'b1, 1'b0, 32'h1C, 32'h4);
    step(1'b1, 1'b0, CTRL, 32'h1);
    prev    = out_o[RW +: RW];
    changes = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b1, 32'h14, 32'h0);
      if (out_o[RW +: RW] !== prev) changes++;
      prev = out_o[RW +: RW];
      checks++;
      if (out_o !== m_out() || blink_phase !== m_phase() || io_read_data !== m_rd) begin
        errors++;
        $display("FAIL blink_cycle%0d: got out=%h ph=%b rd=%h expected out=%h ph=%b rd=%h",
                 k, out_o, blink_phase, io_read_data, m_out(), m_phase(), m_rd);
      end
    end
    checks++;
    if (changes != 16 / BD) begin
      errors++; $display("FAIL blink_toggles: got %0d expected %0d", changes, 16 / BD);
    end
    step(1'b0, 1'b1, 32'h10, 32'h0);
    checks++;
    if (io_read_data !== 32'h4) begin
      errors++; $display("FAIL blink_value_read: got %h expected 4", io_read_data);
    end
  endtask

  task automatic test_restart();
    int n;
    step(1'b1, 1'b0, CTRL, 32'h1);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (blink_phase !== 1'b1 || out_o[RW +: RW] !== 18'h0) begin
      errors++; $display("FAIL restart_pre: got ph=%b ch1=%h expected 1/0", blink_phase, out_o[RW +: RW]);
    end
    step(1'b1, 1'b0, CTRL, 32'h1);
    checks++;
    if (blink_phase !== 1'b0 || out_o[RW +: RW] !== 18'h4) begin
      errors++; $display("FAIL restart_mid: got ph=%b ch1=%h expected 0/4", blink_phase, out_o[RW +: RW]);
    end
    n = 0;
    while (blink_phase === 1'b0 && n < 20) begin
      step(1'b0, 1'b0, 32'h0, 32'h0);
      n++;
    end
    checks++;
    if (n != BD) begin
      errors++; $display("FAIL restart_toggle_delay: got %0d cycles expected %0d", n, BD);
    end
    // Restart landing on the terminal count must suppress the toggle.
    step(1'b1, 1'b0, CTRL, 32'h1);
    for (int k = 0; k < BD - 1; k++) step(1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, CTRL, 32'h1);
    checks++;
    if (blink_phase !== 1'b0 || blink_phase !== m_phase()) begin
      errors++; $display("FAIL restart_terminal: got ph=%b expected 0", blink_phase);
    end
    n = 0;
    while (blink_phase === 1'b0 && n < 20) begin
      step(1'b0, 1'b0, 32'h0, 32'h0);
      n++;
    end
    checks++;
    if (n != BD) begin
      errors++; $display("FAIL restart_terminal_delay: got %0d cycles expected %0d", n, BD);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 32'h00, 32'h12345);
    step(1'b1, 1'b0, 32'h0C, 32'h3FFFF);
    step(1'b1, 1'b0, CTRL, 32'h1);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (out_o[0 +: RW] !== (18'h12345 ^ 18'h3FFFF) || blink_phase !== 1'b1) begin
      errors++; $display("FAIL async_pre: got ch0=%h ph=%b expected %h/1", out_o[0 +: RW], blink_phase, 18'h12345 ^ 18'h3FFFF);
    end
    #2 reset = 1'b1;
    m_reset();
    #1;
    checks++;
    if (out_o[0 +: RW] !== 18'h0 || blink_phase !== 1'b0) begin
      errors++; $display("FAIL async_immediate: got ch0=%h ph=%b expected 0/0", out_o[0 +: RW], blink_phase);
    end
    checks++;
    if (out_o !== m_out() || io_read_data !== 32'h0) begin
      errors++; $display("FAIL async_state: got out=%h rd=%h expected out=%h rd=0", out_o, io_read_data, m_out());
    end
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b1, 32'h0C, 32'h0);
    checks++;
    if (io_read_data !== 32'h0) begin
      errors++; $display("FAIL async_blink_en: got %h expected 0", io_read_data);
    end
  endtask

  task automatic test_unmapped();
    step(1'b1, 1'b0, 32'h64, 32'hFFFFFFFF);
    checks++;
    if (out_o !== m_out()) begin
      errors++; $display("FAIL unmapped_write: got %h expected %h", out_o, m_out());
    end
    step(1'b0, 1'b1, 32'h64, 32'h0);
    checks++;
    if (io_read_data !== 32'h0) begin
      errors++; $display("FAIL unmapped_read: got %h expected 0", io_read_data);
    end
    step(1'b1, 1'b0, 32'h02, 32'hFFFFFFFF);
    step(1'b0, 1'b1, 32'h00, 32'h0);
    checks++;
    if (io_read_data !== 32'h0 || out_o !== m_out()) begin
      errors++; $display("FAIL unaligned_write: got rd=%h out=%h expected 0/%h", io_read_data, out_o, m_out());
    end
    step(1'b0, 1'b1, 32'h20, 32'h0);
    step(1'b0, 1'b0, 32'h00, 32'h0);
    step(1'b0, 1'b0, 32'h64, 32'h0);
    checks++;
    if (io_read_data !== 32'h0003FFFF) begin
      errors++; $display("FAIL read_hold: got %h expected 0003ffff", io_read_data);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 32'h30, 32'h2AAAA);
    step(1'b1, 1'b1, 32'h30, 32'h15555);
    checks++;
    if (io_read_data !== 32'h0002AAAA) begin
      errors++; $display("FAIL rw_same_cycle: got %h expected 0002aaaa", io_read_data);
    end
    step(1'b0, 1'b1, 32'h30, 32'h0);
    checks++;
    if (io_read_data !== 32'h00015555) begin
      errors++; $display("FAIL rw_followup: got %h expected 00015555", io_read_data);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic we, re;
    int sel;
    for (int k = 0; k < 400; k++) begin
      sel = int'($urandom_range(0, 11));
      d   = $urandom;
      if (sel < 9)       a = 32'($urandom_range(0, NR - 1) * 16 + $urandom_range(0, 3) * 4);
      else if (sel == 9) a = CTRL;
      else if (sel == 10) a = 32'($urandom_range(0, 7) * 16 + $urandom_range(1, 3));
      else               a = 32'h64 + 32'($urandom_range(0, 4) * 4);
      we = ($urandom_range(0, 1) == 1);
      re = ($urandom_range(0, 3) != 0);
      if (a == CTRL && $urandom_range(0, 3) != 0) d[0] = 1'b0;
      step(we, re, a, d);
      checks++;
      if (out_o !== m_out() || blink_phase !== m_phase() || io_read_data !== m_rd) begin
        errors++;
        $display("FAIL random_%0d a=%h: got out=%h ph=%b rd=%h expected out=%h ph=%b rd=%h",
                 k, a, out_o, blink_phase, io_read_data, m_out(), m_phase(), m_rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_value_set_clear();
    test_blink();
    test_restart();
    test_async_reset();
    test_unmapped();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/io_output_bank.md
Name: io_output_bank

Overview:
Parametrised bank of memory-mapped output registers on the processor IO bus (io_write_en/io_address/io_write_data). It generalises the fixed LED and seven-segment registers to NUM_REGS channels of REG_WIDTH bits, each with a per-channel reset polarity. Each channel adds atomic SET/CLEAR aliases, hardware blink via a shared prescaler, and registered readback. The top level instantiates one per LED/segment group and feeds io_read_data into its read mux.

Parameters:
BASE_ADDRESS, 0, byte address of channel 0 VALUE register
NUM_REGS, 6, number of output channels (1..16)
REG_WIDTH, 18, bits per channel (1..32)
RESET_MASK, 0, NUM_REGS-bit vector; bit i=1 -> channel i VALUE resets to all ones, else zero
BLINK_DIVIDE, 25000000, clocks per blink half-period (>=2)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
io_write_en  input  1  IO write strobe
io_read_en  input  1  IO read strobe
io_address  input  32  IO byte address
io_write_data  input  32  IO write data
io_read_data  output  32  registered read data
out_o  output  NUM_REGS*REG_WIDTH  displayed values; channel i in bits [i*REG_WIDTH +: REG_WIDTH]
blink_phase  output  1  current blink phase

Behaviour:
- Address map, full 32-bit compare; channel i window at A = BASE_ADDRESS + 16*i:
  - A+0 VALUE: R/W.
  - A+4 SET: write ORs data into VALUE; read returns displayed value.
  - A+8 CLEAR: write ANDs ~data into VALUE; read returns 0.
  - A+12 BLINK_EN: R/W per-bit blink enable.
  - CTRL at BASE_ADDRESS + 16*NUM_REGS: write with bit0=1 restarts the prescaler; read returns {31'b0, blink_phase}.
  - Any other address, including unaligned ones, is unmapped: writes are ignored and reads return 0.
- Write data bits above REG_WIDTH are ignored. Reads zero-extend to 32 bits.
- Writes take effect on the clock edge where io_write_en=1. The new VALUE appears on out_o the next cycle. Only one write per cycle is possible.
- Read latency is 1 cycle. io_read_data loads the decoded value on the edge where io_read_en=1 and holds otherwise. The read path is independent of io_write_en; a read and a write to the same register in the same cycle returns the old value.
- Display: out_o channel i = VALUE[i] ^ (BLINK_EN[i] & {REG_WIDTH{blink_phase}}). The XOR is polarity-agnostic (works for active-low segments). out_o is registered.
- Prescaler:
  - Counter width is $clog2(BLINK_DIVIDE). It counts 0..BLINK_DIVIDE-1.
  - At BLINK_DIVIDE-1 the counter wraps to 0 and blink_phase toggles.
  - A CTRL restart clears the counter to 0 and blink_phase to 0. If the restart coincides with the terminal count, the restart wins and there is no toggle.
  - The next toggle occurs exactly BLINK_DIVIDE cycles after a restart.
- Reset values (asynchronous, immediate, including mid-blink):
  - VALUE[i] = RESET_MASK[i] ? all ones : 0.
  - BLINK_EN = 0.
  - counter = 0, blink_phase = 0, io_read_data = 0.
  - out_o shows the VALUE reset values from assertion.
- SET or CLEAR with data 0 leaves VALUE unchanged. A VALUE write does not disturb BLINK_EN or the prescaler.

Test Plan:
Config for all tests: NUM_REGS=6, REG_WIDTH=18, BASE=0, RESET_MASK=6'b111100, BLINK_DIVIDE=4.
1. Reset release -> out_o ch0=0x00000, ch1=0x00000, ch2..5=0x3FFFF. Read 0x20 -> io_read_data=0x0003FFFF one cycle later. Read 0x60 -> 0.
2. Write 0x00 data 0xFFFFFFFF -> ch0=0x3FFFF, readback 0x0003FFFF. Then write 0x14 SET 0x5, then 0x18 CLEAR 0x1 -> ch1=0x00004. Read 0x18 -> 0.
3. Write 0x1C BLINK_EN=0x4 with ch1=0x4 -> out_o ch1 alternates 0x4 and 0x0, each held exactly 4 cycles. Read 0x14 tracks the displayed value; read 0x10 stays 0x4.
4. Mid-period (counter=2, phase=1), write CTRL 0x60 data 1 -> blink_phase=0 next cycle, ch1 display=0x4, next toggle exactly 4 cycles later. Restart coinciding with terminal count -> no toggle.
5. Assert reset asynchronously mid-blink with ch0=0x12345 -> out_o ch0=0 and blink_phase=0 immediately, without waiting for a clock edge. After release, BLINK_EN reads 0.
6. Unmapped accesses:
   - Write 0x64 data 0xFFFFFFFF -> no register changes; read 0x64 -> 0.
   - Write 0x02 (unaligned) -> ignored.
   - Read with io_read_en=0 -> io_read_data holds its previous value.
